// File: rtl/dec_to_binary.sv
// Packed-BCD to binary converter: one multiply-by-ten-and-add step per clock,
// started by a single-cycle start in IDLE and finished with a one-cycle done pulse.
module dec_to_binary #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [OUT_W-1:0]      bin_out,
  output logic [1:0]            state_dbg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] operand;
  logic [OUT_W-1:0]    acc;
  logic [OUT_W-1:0]    acc_next;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          digit;
  logic                bad_nibble;

  assign state_dbg = state;

  // Any nibble above 9 makes the whole operand invalid.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*4 +: 4] > 4'd9) bad_nibble = 1'b1;
    end
  end

  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) digit = operand[i*4 +: 4];
    end
  end

  // acc*10 + digit; the parameter rule guarantees this never wraps.
  assign acc_next = (acc << 3) + (acc << 1) + OUT_W'(digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
      acc     <= '0;
      idx     <= '0;
      operand <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            operand <= bcd_in;
            acc     <= '0;
            idx     <= IDX_W'(DIGITS - 1);
            busy    <= 1'b1;
            if (bad_nibble) begin
              err     <= 1'b1;
              bin_out <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              err   <= 1'b0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          acc <= acc_next;
          if (idx == '0) begin
            bin_out <= acc_next;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_to_binary.sv
// Directed bench for dec_to_binary: a 4-digit instance and a 2-digit instance
// checked against hand-computed results, latencies and handshake timing.
module tb_dec_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy, done, err;
  logic [13:0] bin_out;
  logic [1:0]  state_dbg;

  logic        start2;
  logic [7:0]  bcd2;
  logic        busy2, done2, err2;
  logic [6:0]  bin2;
  logic [1:0]  state_dbg2;

  int n_checks = 0;
  int n_fail   = 0;

  dec_to_binary #(.DIGITS(4), .OUT_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out),
    .state_dbg(state_dbg)
  );

  dec_to_binary #(.DIGITS(2), .OUT_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .err(err2), .bin_out(bin2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: launch one conversion on the 4-digit instance and
  // follow it to its done pulse, checking latency, busy length and result.
  task automatic run_conv(input string tag, input logic [15:0] bcd,
                          input int exp_bin, input logic exp_err, input int exp_lat);
    int lat;
    int busy_cnt;
    bcd_in = bcd;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, "_bin"}, bin_out, exp_bin);
    chk({tag, "_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_bin_hold"}, bin_out, exp_bin);
    chk({tag, "_err_hold"}, err, exp_err);
  endtask

  initial begin
    int lat;
    int n_done;
    rst    = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    start2 = 1'b0;
    bcd2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b1;
    @(negedge clk);

    // valid operands, including all-nines and all-zeros
    run_conv("c1234", 16'h1234, 1234, 1'b0, 5);
    run_conv("c9999", 16'h9999, 9999, 1'b0, 5);
    run_conv("c0000", 16'h0000, 0, 1'b0, 5);
    run_conv("c9999b", 16'h9999, 9999, 1'b0, 5);

    // invalid nibble clears bin_out, sets err; next valid start clears err
    run_conv("c12a4", 16'h12A4, 0, 1'b1, 1);
    run_conv("c0042", 16'h0042, 42, 1'b0, 5);

    // start while busy is ignored; bcd_in change after acceptance is ignored
    bcd_in = 16'h0500;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0777;
    @(negedge clk);
    start  = 1'b0;
    lat    = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start_latency", lat, 5);
    chk("busy_start_bin", bin_out, 500);
    chk("busy_start_err", err, 0);
    @(negedge clk);
    chk("busy_start_idle_busy", busy, 0);
    chk("busy_start_idle_state", state_dbg, 0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("busy_start_not_queued", n_done, 0);
    chk("busy_start_bin_hold", bin_out, 500);

    // asynchronous reset mid-conversion
    bcd_in = 16'h8765;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_bin", bin_out, 0);
    chk("abort_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || err || (bin_out != 0)) n_done++;
    end
    chk("post_abort_quiet", n_done, 0);

    // start held high: back-to-back conversions every DIGITS+2 cycles
    bcd_in = 16'h0001;
    start  = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk($sformatf("held_done_c%0d", c), done, ((c % 6) == 5) ? 1 : 0);
      if (done) begin
        n_done++;
        chk($sformatf("held_bin_c%0d", c), bin_out, 1);
      end
    end
    start = 1'b0;
    chk("held_done_count", n_done, 3);
    repeat (8) @(negedge clk);

    // 2-digit instance
    bcd2   = 8'h99;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat    = 1;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("d2_latency", lat, 3);
    chk("d2_bin", bin2, 99);
    chk("d2_err", err2, 0);
    @(negedge clk);
    chk("d2_busy_after", busy2, 0);

    bcd2   = 8'h9B;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("d2_bad_done", done2, 1);
    chk("d2_bad_err", err2, 1);
    chk("d2_bad_bin", bin2, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
